// File: rtl/timer_pkg.sv
// Shared constants and sizing helpers for the playback timer and its BCD display path.
package timer_pkg;

    localparam int unsigned BCD_W = 4;

    function automatic int unsigned calc_max_sec(input int unsigned min_digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < min_digits; i++) begin
            p = p * 10;
        end
        return 60 * p - 1;
    endfunction

    function automatic int unsigned calc_sec_w(input int unsigned min_digits);
        return $clog2(calc_max_sec(min_digits) + 1);
    endfunction

endpackage

// File: rtl/sec_to_bcd.sv
// Combinational binary-seconds to m..m:ss BCD converter for the 7-segment driver.
module sec_to_bcd
    import timer_pkg::*;
#(
    parameter  int unsigned MIN_DIGITS = 2,
    localparam int unsigned SEC_W      = calc_sec_w(MIN_DIGITS)
) (
    input  logic [SEC_W-1:0]            i_sec,
    output logic [BCD_W-1:0]            o_seconds0,
    output logic [BCD_W-1:0]            o_seconds1,
    output logic [BCD_W*MIN_DIGITS-1:0] o_minutes
);

    logic [SEC_W-1:0] w_min;
    logic [SEC_W-1:0] w_sec;
    logic [SEC_W-1:0] w_rem;

    always_comb begin
        w_min      = i_sec / SEC_W'(60);
        w_sec      = i_sec % SEC_W'(60);
        o_seconds0 = BCD_W'(w_sec % SEC_W'(10));
        o_seconds1 = BCD_W'(w_sec / SEC_W'(10));
        o_minutes  = '0;
        w_rem      = w_min;
        // Peel minute digits off least-significant first.
        for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
            o_minutes[i*BCD_W +: BCD_W] = BCD_W'(w_rem % SEC_W'(10));
            w_rem = w_rem / SEC_W'(10);
        end
    end

endmodule

// File: rtl/track_timer.sv
// Playback-position timer: signed step per prescaled tick, clamped to [0, track length],
// with seek load, end-of-track flags and BCD digit outputs.
module track_timer
    import timer_pkg::*;
#(
    parameter  int unsigned MIN_DIGITS = 2,
    parameter  int unsigned TICK_DIV   = 1,
    parameter  int unsigned STEP_W     = 9,
    localparam int unsigned SEC_W      = calc_sec_w(MIN_DIGITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        count,
    input  logic signed [STEP_W-1:0]    adder,
    input  logic                        load,
    input  logic [SEC_W-1:0]            load_sec,
    input  logic [SEC_W-1:0]            limit_sec,
    output logic [BCD_W-1:0]            seconds0,
    output logic [BCD_W-1:0]            seconds1,
    output logic [BCD_W*MIN_DIGITS-1:0] minutes,
    output logic                        at_zero,
    output logic                        at_limit,
    output logic                        done,
    output logic                        rewound
);

    localparam int unsigned MAX_SEC = calc_max_sec(MIN_DIGITS);
    localparam int unsigned EXT_W   = ((SEC_W > STEP_W) ? SEC_W : STEP_W) + 2;
    localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [SEC_W-1:0]        r_pos;
    logic [PRE_W-1:0]        r_pre;
    logic                    r_prev_zero;
    logic                    r_prev_limit;
    logic                    r_done;
    logic                    r_rewound;

    logic [SEC_W-1:0]        w_lim;
    logic [SEC_W-1:0]        w_load_pos;
    logic                    w_tick;
    logic signed [EXT_W-1:0] w_pos_ext;
    logic signed [EXT_W-1:0] w_add_ext;
    logic signed [EXT_W-1:0] w_lim_ext;
    logic signed [EXT_W-1:0] w_sum;
    logic [SEC_W-1:0]        w_step_pos;
    logic                    w_at_zero;
    logic                    w_at_limit;

    assign w_lim      = (limit_sec > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : limit_sec;
    assign w_load_pos = (load_sec > w_lim) ? w_lim : load_sec;
    assign w_tick     = count && (r_pre == PRE_W'(TICK_DIV - 1));

    assign w_pos_ext  = $signed({{(EXT_W-SEC_W){1'b0}}, r_pos});
    assign w_add_ext  = $signed({{(EXT_W-STEP_W){adder[STEP_W-1]}}, adder});
    assign w_lim_ext  = $signed({{(EXT_W-SEC_W){1'b0}}, w_lim});
    assign w_sum      = w_pos_ext + w_add_ext;

    // Saturate the stepped position into [0, lim]; no wrap-around.
    always_comb begin
        w_step_pos = r_pos;
        if (w_sum[EXT_W-1]) begin
            w_step_pos = '0;
        end else if (w_sum > w_lim_ext) begin
            w_step_pos = w_lim;
        end else begin
            w_step_pos = w_sum[SEC_W-1:0];
        end
    end

    assign w_at_zero  = (r_pos == '0);
    assign w_at_limit = (r_pos == w_lim);

    // History regs reset high: at_limit can only be high at reset when lim==0, so no pulse either way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos        <= '0;
            r_pre        <= '0;
            r_prev_zero  <= 1'b1;
            r_prev_limit <= 1'b1;
            r_done       <= 1'b0;
            r_rewound    <= 1'b0;
        end else begin
            if (load) begin
                r_pos <= w_load_pos;
                r_pre <= '0;
            end else if (count) begin
                r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
                if (w_tick) begin
                    r_pos <= w_step_pos;
                end
            end
            r_prev_zero  <= w_at_zero;
            r_prev_limit <= w_at_limit;
            r_done       <= w_at_limit && !r_prev_limit;
            r_rewound    <= w_at_zero && !r_prev_zero;
        end
    end

    assign at_zero  = w_at_zero;
    assign at_limit = w_at_limit;
    assign done     = r_done;
    assign rewound  = r_rewound;

    sec_to_bcd #(
        .MIN_DIGITS (MIN_DIGITS)
    ) u_sec_to_bcd (
        .i_sec      (r_pos),
        .o_seconds0 (seconds0),
        .o_seconds1 (seconds1),
        .o_minutes  (minutes)
    );

endmodule

// File: tb/tb_track_timer.sv
// Directed bench for track_timer: default instance plus a TICK_DIV=4 instance for prescaler phase.
module tb_track_timer;

    logic              clk = 1'b0;
    logic              reset;
    logic              count;
    logic signed [8:0] adder;
    logic              load;
    logic [12:0]       load_sec;
    logic [12:0]       limit_sec;

    logic [3:0] s0_a, s1_a, s0_b, s1_b;
    logic [7:0] min_a, min_b;
    logic       az_a, al_a, dn_a, rw_a;
    logic       az_b, al_b, dn_b, rw_b;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    track_timer #(.MIN_DIGITS(2), .TICK_DIV(1), .STEP_W(9)) u_dut (
        .clk(clk), .reset(reset), .count(count), .adder(adder), .load(load),
        .load_sec(load_sec), .limit_sec(limit_sec),
        .seconds0(s0_a), .seconds1(s1_a), .minutes(min_a),
        .at_zero(az_a), .at_limit(al_a), .done(dn_a), .rewound(rw_a)
    );

    track_timer #(.MIN_DIGITS(2), .TICK_DIV(4), .STEP_W(9)) u_dut4 (
        .clk(clk), .reset(reset), .count(count), .adder(adder), .load(load),
        .load_sec(load_sec), .limit_sec(limit_sec),
        .seconds0(s0_b), .seconds1(s1_b), .minutes(min_b),
        .at_zero(az_b), .at_limit(al_b), .done(dn_b), .rewound(rw_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int to_sec(input logic [7:0] m, input logic [3:0] s1, input logic [3:0] s0);
        return (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 + int'(s1) * 10 + int'(s0);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int np;
        reset = 1'b0; count = 1'b0; adder = 9'sd0; load = 1'b0;
        load_sec = 13'd0; limit_sec = 13'd5999;
        #1;
        chk("rst_pos", to_sec(min_a, s1_a, s0_a), 0);
        chk("rst_at_zero", int'(az_a), 1);
        chk("rst_at_limit", int'(al_a), 0);
        chk("rst_done", int'(dn_a), 0);
        chk("rst_rewound", int'(rw_a), 0);

        // Count up by 1 for 75 clocks -> 01:15.
        step(1);
        reset = 1'b1; count = 1'b1; adder = 9'sd1;
        step(75);
        chk("run_min", int'(min_a), 'h01);
        chk("run_s1", int'(s1_a), 1);
        chk("run_s0", int'(s0_a), 5);
        chk("run_at_zero", int'(az_a), 0);

        // Pause and resume.
        count = 1'b0;
        step(100);
        chk("pause_pos", to_sec(min_a, s1_a, s0_a), 75);
        count = 1'b1;
        step(1);
        chk("resume_pos", to_sec(min_a, s1_a, s0_a), 76);

        // Rewind past zero clamps and pulses once.
        load_sec = 13'd5; load = 1'b1;
        step(1);
        chk("seek5_pos", to_sec(min_a, s1_a, s0_a), 5);
        load = 1'b0; adder = -9'sd10;
        step(1);
        chk("rew_pos", to_sec(min_a, s1_a, s0_a), 0);
        chk("rew_at_zero", int'(az_a), 1);
        chk("rew_pulse_early", int'(rw_a), 0);
        step(1);
        chk("rew_pulse", int'(rw_a), 1);
        step(1);
        chk("rew_pulse_end", int'(rw_a), 0);
        np = 0;
        repeat (5) begin
            step(1);
            np += int'(rw_a);
        end
        chk("rew_no_repulse", np, 0);
        chk("rew_hold_pos", to_sec(min_a, s1_a, s0_a), 0);

        // Fast-forward into the limit, then rewind from it.
        limit_sec = 13'd200; load_sec = 13'd190; load = 1'b1; adder = 9'sd15;
        step(1);
        chk("lim_load_pos", to_sec(min_a, s1_a, s0_a), 190);
        load = 1'b0;
        step(1);
        chk("lim_min", int'(min_a), 'h03);
        chk("lim_s1", int'(s1_a), 2);
        chk("lim_s0", int'(s0_a), 0);
        chk("lim_at_limit", int'(al_a), 1);
        chk("lim_done_early", int'(dn_a), 0);
        step(1);
        chk("lim_done", int'(dn_a), 1);
        step(1);
        chk("lim_done_end", int'(dn_a), 0);
        chk("lim_hold_pos", to_sec(min_a, s1_a, s0_a), 200);
        adder = -9'sd30;
        step(1);
        chk("back_min", int'(min_a), 'h02);
        chk("back_s1", int'(s1_a), 5);
        chk("back_s0", int'(s0_a), 0);
        chk("back_at_limit", int'(al_a), 0);

        // Seek beyond MAX_SEC with an oversized limit -> 99:59.
        count = 1'b0; limit_sec = 13'd7000; load_sec = 13'd8000; load = 1'b1;
        step(1);
        chk("max_min", int'(min_a), 'h99);
        chk("max_s1", int'(s1_a), 5);
        chk("max_s0", int'(s0_a), 9);
        chk("max_at_limit", int'(al_a), 1);
        load = 1'b0;
        step(1);
        chk("max_done", int'(dn_a), 1);
        step(1);
        chk("max_done_end", int'(dn_a), 0);

        // Short asynchronous reset mid-tick with load asserted.
        count = 1'b1; adder = 9'sd1; load = 1'b1; load_sec = 13'd100; limit_sec = 13'd5999;
        #2 reset = 1'b0;
        #1;
        chk("areset_pos", to_sec(min_a, s1_a, s0_a), 0);
        chk("areset_at_zero", int'(az_a), 1);
        chk("areset_at_limit", int'(al_a), 0);
        chk("areset_done", int'(dn_a), 0);
        #2 reset = 1'b1; load = 1'b0;
        step(1);
        chk("post_rst_pos", to_sec(min_a, s1_a, s0_a), 1);
        chk("post_rst_rewound", int'(rw_a), 0);
        chk("post_rst_done", int'(dn_a), 0);
        step(1);
        chk("post_rst_pos2", to_sec(min_a, s1_a, s0_a), 2);
        chk("post_rst_rewound2", int'(rw_a), 0);

        // Zero-length track: next tick clamps to 0, both flags high, both pulse once.
        limit_sec = 13'd0;
        step(1);
        chk("zlim_pos", to_sec(min_a, s1_a, s0_a), 0);
        chk("zlim_at_zero", int'(az_a), 1);
        chk("zlim_at_limit", int'(al_a), 1);
        step(1);
        chk("zlim_rewound", int'(rw_a), 1);
        chk("zlim_done", int'(dn_a), 1);
        step(1);
        chk("zlim_rewound_end", int'(rw_a), 0);
        chk("zlim_done_end", int'(dn_a), 0);
        chk("zlim_flags", int'(az_a & al_a), 1);

        // TICK_DIV=4: prescaler phase survives a pause; load beats a coincident tick.
        limit_sec = 13'd5999; adder = 9'sd1; load_sec = 13'd0; load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        count = 1'b0;
        step(10);
        count = 1'b1;
        step(1);
        chk("div4_pre3_pos", to_sec(min_b, s1_b, s0_b), 0);
        step(1);
        chk("div4_tick_pos", to_sec(min_b, s1_b, s0_b), 1);
        step(3);
        chk("div4_wait_pos", to_sec(min_b, s1_b, s0_b), 1);
        load_sec = 13'd50; load = 1'b1;
        step(1);
        chk("div4_load_pos", to_sec(min_b, s1_b, s0_b), 50);
        load = 1'b0;
        step(3);
        chk("div4_post_load3", to_sec(min_b, s1_b, s0_b), 50);
        step(1);
        chk("div4_post_load4", to_sec(min_b, s1_b, s0_b), 51);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
